// File: rtl/iter_counter_pkg.sv
// iter_counter_pkg
// Shared definitions for the iteration sequencer: FSM state encoding and the
// default count/limit width.
//
// Optional feature macro used by the files of this block: ITER_COUNTER_DOWN_EN
// (adds a down-count direction to iter_counter).
package iter_counter_pkg;

    // Default width of count and limit; the maximum run length is 2^WIDTH steps.
    localparam int DEFAULT_WIDTH = 4;

    // FSM state encoding.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage : iter_counter_pkg

// File: rtl/add_sub.sv
// add_sub
// Combinational adder/subtractor. The result wraps modulo 2^WIDTH.
//
// Ports:
//   a      : first operand
//   b      : second operand
//   sub    : 0 -> a + b, 1 -> a - b
//   result : sum or difference, WIDTH bits
module add_sub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result
);

    // Single shared add/subtract path selected by sub.
    always_comb begin
        if (sub) begin
            result = a - b;
        end else begin
            result = a + b;
        end
    end

endmodule : add_sub

// File: rtl/iter_counter_step.sv
// iter_step
// One iteration step of the sequencer: the incremented or decremented count
// and the flag saying the current count is the terminal one.
//
// Ports:
//   count      : current iteration index
//   limit_q    : terminal count captured at start
//   dir        : 0 -> count up towards limit_q, 1 -> count down towards 0
//   next_count : count +/- 1, modulo 2^WIDTH
//   at_term    : count equals the terminal target (limit_q, or 0 when dir=1)
module iter_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit_q,
    input  logic             dir,
    output logic [WIDTH-1:0] next_count,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1'b1);

    logic [WIDTH-1:0] target_s;

    add_sub #(
        .WIDTH (WIDTH)
    ) u_add_sub (
        .a      (count),
        .b      (STEP_ONE),
        .sub    (dir),
        .result (next_count)
    );

    // Terminal target: the captured limit when counting up, zero when counting down.
    always_comb begin
        if (dir) begin
            target_s = {WIDTH{1'b0}};
        end else begin
            target_s = limit_q;
        end
    end

    assign at_term = (count == target_s);

endmodule : iter_step

// File: rtl/iter_counter.sv
// iter_counter
// Iteration sequencer for multi-cycle ALU operations (Booth multiply,
// restoring divide). Control issues start with a terminal count, the datapath
// steps it with enable, and done pulses one cycle after the final step.
//
// Optional feature macro: ITER_COUNTER_DOWN_EN
//   defined   : adds input 'down'; a run started with down=1 loads count with
//               limit and decrements to 0 (still limit+1 steps).
//   undefined : up-count only.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, clears all state
//   start  : begin a run (honoured in IDLE or DONE only)
//   limit  : terminal count, sampled with start
//   enable : advance one iteration (RUN only)
//   abort  : cancel an active run without a done pulse
//   down   : (ITER_COUNTER_DOWN_EN only) count direction, sampled with start
//   count  : current iteration index
//   busy   : high while in RUN
//   last   : combinational, final iteration in progress
//   done   : registered one-cycle pulse after the final iteration
module iter_counter
    import iter_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             enable,
    input  logic             abort,
`ifdef ITER_COUNTER_DOWN_EN
    input  logic             down,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nx_s;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] limit_nx_s;
    logic             busy_r;
    logic             done_r;
    logic             dir_s;
    logic             dir_nx_s;
    logic [WIDTH-1:0] step_count_s;
    logic             at_term_s;
    logic [WIDTH-1:0] start_count_s;

`ifdef ITER_COUNTER_DOWN_EN
    logic dir_r;

    assign dir_s    = dir_r;
    assign dir_nx_s = down;
`else
    assign dir_s    = 1'b0;
    assign dir_nx_s = 1'b0;
`endif

    iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .count      (count_r),
        .limit_q    (limit_r),
        .dir        (dir_s),
        .next_count (step_count_s),
        .at_term    (at_term_s)
    );

    // Count value loaded by start: the limit for a down run, zero for an up run.
    always_comb begin
        if (dir_nx_s) begin
            start_count_s = limit;
        end else begin
            start_count_s = {WIDTH{1'b0}};
        end
    end

    // Next-state logic; abort outranks start, start outranks enable.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        limit_nx_s = limit_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (start) begin
                    state_nx_s = ST_RUN;
                    count_nx_s = start_count_s;
                    limit_nx_s = limit;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (enable) begin
                    // Termination by equality: the count never wraps past the target.
                    if (at_term_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        count_nx_s = step_count_s;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, count, captured limit and the registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= {WIDTH{1'b0}};
            limit_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            count_r <= count_nx_s;
            limit_r <= limit_nx_s;
            busy_r  <= (state_nx_s == ST_RUN);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

`ifdef ITER_COUNTER_DOWN_EN
    // Direction is captured only when a run is actually launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_r <= 1'b0;
        end else if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && !abort && start) begin
            dir_r <= dir_nx_s;
        end else begin
            dir_r <= dir_r;
        end
    end
`endif

    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign last  = busy_r && at_term_s;

endmodule : iter_counter

// File: doc/iter_counter.md
Name: iter_counter

Overview:
Parametrised iteration sequencer for the multi-cycle ALU operations: Booth multiply and restoring divide.
- Generalises the free-running enable counter with a programmable terminal count, start/busy/done handshake, abort, and final-iteration flag.
- Sits between the ALU control FSM and the datapath.
- Control issues start with an iteration limit, steps the count once per datapath iteration, and receives a one-cycle done pulse.

Parameters:
WIDTH, 4, count and limit width; max iterations = 2^WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all state
start  input  1  begin a run; sampled only in IDLE or DONE
limit  input  WIDTH  terminal count, sampled with start; run length = limit+1 enabled steps
enable  input  1  advance one iteration (ignored outside RUN)
abort  input  1  cancel an active run, with no done pulse
count  output  WIDTH  current iteration index
busy  output  1  high while in RUN
last  output  1  combinational: busy && count==limit_q (final iteration in progress)
done  output  1  registered one-cycle pulse after the final iteration

Behaviour:
- States: IDLE, RUN, DONE; encoding is defined in the package.
- Reset (clk edge with reset=1): state=IDLE, count=0, limit_q=0, busy=0, done=0. Reset overrides every other input, including mid-run.
- Priority within a cycle: reset > abort > start > enable.
- IDLE:
  - start=1: limit_q<=limit, count<=0, go to RUN. busy goes high the next cycle.
  - start=0: hold; count keeps its last value.
- RUN:
  - enable=1 and count!=limit_q: count<=count+1, mod 2^WIDTH via the add_sub instance.
  - enable=1 and count==limit_q: go to DONE; count holds at limit_q.
  - enable=0: hold everything.
  - abort=1: go to IDLE; count holds; done is not asserted.
  - start in RUN: ignored; limit_q is unchanged.
- DONE:
  - done=1 and busy=0 for exactly this one cycle.
  - Next state is IDLE.
  - start=1 in DONE: load limit, count<=0, go directly to RUN (back-to-back runs, zero bubble). done is still 1 in that cycle.
- Latency: start to first RUN cycle = 1 clk. Last enabled step to done = 1 clk.
- limit=0: a single enabled step ends the run. last is 1 in the first RUN cycle.
- limit=2^WIDTH-1: count reaches all-ones, then stops. No wrap occurs because termination is by equality.
- The limit input is a don't-care except in the start cycle.

Optional Feature:
ITER_COUNTER_DOWN_EN
- Defined:
  - Adds input port `down` (1 bit), sampled with start into dir_q.
  - When dir_q=1, start loads count<=limit, enable decrements (add_sub sub=1), and the terminal condition is count==0.
  - last = busy && count==0.
  - Run length stays limit+1 steps.
- Undefined: no `down` port; up-count only; add_sub sub is tied to 0.

Decomposition:
- Package iter_counter_pkg: state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
- One sub-module, iter_step:
  - Wraps add_sub with a constant-one operand and direction-driven sub.
  - Includes the terminal-compare against the selected target (limit_q or 0).
  - Outputs next_count and at_term.
- The top level holds the FSM and the state/count/limit_q registers.

Test Plan:
1. Reset mid-run: start limit=5, step 3 times (count=3), assert reset 1 cycle -> next cycle count=0, busy=0, done=0, state IDLE.
2. Booth run, WIDTH=3: start limit=7, enable held high -> count 0..7 over 8 RUN cycles; last=1 only at count=7; done=1 exactly one cycle after; then idle.
3. Stall and abort: limit=4, toggle enable 1,0,1,0 -> count advances only on enabled cycles. Abort at count=2 -> IDLE next cycle, count=2, no done pulse.
4. Boundaries: (a) limit=0 -> last=1 in the first RUN cycle; one step gives done. (b) limit=15 at WIDTH=4 -> 16 steps, count stops at 15 with no wrap.
5. Back-to-back runs: start=1 during the DONE cycle with limit=2 -> next cycle busy=1, count=0; start during RUN is ignored (limit_q unchanged).
6. ITER_COUNTER_DOWN_EN: down=1, limit=6 -> count 6,5,...,0; last at 0; done after 7 steps. Without the macro, the build has no `down` port.
